// File: rtl/quadrature_step_decoder.sv
// Quadrature step decoder: synchronises the A/B pins, filters glitches and
// decodes Gray transitions into a one-cycle step pulse plus a direction level.
// Optional build macro: QDEC_ERR_CNT_EN adds a saturating illegal-transition
// counter on port err_cnt.
module quadrature_step_decoder #(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned ERR_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [1:0]       ab_state
`ifdef QDEC_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILT_LEN);

  // Reject parameter values the filter counter cannot represent
  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt
    $error("FILT_LEN must be in 1..15");
  end
  if (ERR_W < 1) begin : g_bad_err_w
    $error("ERR_W must be at least 1");
  end

  logic             a_s1, a_s2, b_s1, b_s2;
  logic [1:0]       sync_pair;
  logic [1:0]       pair_q;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             qual;

  logic             primed_q, primed_nxt;
  logic [1:0]       ab_q, ab_nxt;
  logic             dir_q, dir_nxt;
  logic             err_q, err_nxt;
  logic             step_q, step_nxt;
  logic             illegal;

  // Two-flop synchroniser per pin
  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= a_in;
      a_s2 <= a_s1;
      b_s1 <= b_in;
      b_s2 <= b_s1;
    end
  end

  assign sync_pair = {a_s2, b_s2};

  // Stability count: grows while the pair is unchanged, reloads to 1 on change
  always_comb begin
    cnt_nxt = CNT_W'(1);
    if (sync_pair == pair_q) begin
      cnt_nxt = (cnt_q >= FILT_MAX) ? FILT_MAX : cnt_q + CNT_W'(1);
    end
  end

  assign qual = (cnt_nxt == FILT_MAX);

  // Filter history and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q <= 2'b00;
      cnt_q  <= '0;
    end else begin
      pair_q <= sync_pair;
      cnt_q  <= cnt_nxt;
    end
  end

  // Priming and Gray transition decode on the qualifying edge
  always_comb begin
    primed_nxt = primed_q;
    ab_nxt     = ab_q;
    dir_nxt    = dir_q;
    step_nxt   = 1'b0;
    illegal    = 1'b0;
    if (qual) begin
      if (!primed_q) begin
        primed_nxt = 1'b1;
        ab_nxt     = sync_pair;
      end else if (sync_pair != ab_q) begin
        ab_nxt = sync_pair;
        case ({ab_q, sync_pair})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
            dir_nxt  = 1'b1;
            step_nxt = en;
          end
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
            dir_nxt  = 1'b0;
            step_nxt = en;
          end
          default: illegal = 1'b1;
        endcase
      end
    end
    err_nxt = err_q | illegal;
  end

  // Decoder state register; reset wins over any update on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q <= 1'b0;
      ab_q     <= 2'b00;
      dir_q    <= 1'b1;
      err_q    <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      primed_q <= primed_nxt;
      ab_q     <= ab_nxt;
      dir_q    <= dir_nxt;
      err_q    <= err_nxt;
      step_q   <= step_nxt;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign err      = err_q;
  assign ab_state = ab_q;

`ifdef QDEC_ERR_CNT_EN
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [ERR_W-1:0] err_cnt_q;

  // Saturating count of illegal transitions, independent of en
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (illegal && (err_cnt_q != ERR_MAX)) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Self-checking bench for quadrature_step_decoder: directed scenarios with
// literal expectations plus a randomized walk checked every cycle against a
// run-length/Gray-position reference model.
module tb_quadrature_step_decoder;

  localparam int unsigned FILT_LEN = 3;
  localparam int unsigned ERR_W    = 4;
  localparam int          ERR_MAX  = (1 << ERR_W) - 1;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       en   = 1'b1;
  logic       step, dir, err;
  logic [1:0] ab_state;
`ifdef QDEC_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  quadrature_step_decoder #(.FILT_LEN(FILT_LEN), .ERR_W(ERR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .en       (en),
    .step     (step),
    .dir      (dir),
    .err      (err),
    .ab_state (ab_state)
`ifdef QDEC_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Position of a pair along the forward Gray cycle 00,01,11,10
  function automatic int gpos(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gval(input int idx);
    case (idx % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Reference model: a pair is accepted once it has been seen on FILT_LEN
  // consecutive edges (pins reach the filter two edges late); the Gray
  // position difference decides forward, reverse or illegal.
  logic [1:0] pins_d1, pins_d2, last_seen, m_ab;
  int         run     = 0;
  int         m_ecnt  = 0;
  bit         m_valid = 1'b0;
  bit         m_primed, m_step, m_dir, m_err;

  always @(posedge clk) begin
    logic [1:0] seen;
    int         d;
    if (rst) begin
      pins_d1 = 2'b00; pins_d2 = 2'b00; last_seen = 2'b00;
      run = 0; m_primed = 1'b0; m_ab = 2'b00;
      m_step = 1'b0; m_dir = 1'b1; m_err = 1'b0; m_ecnt = 0;
      m_valid = 1'b1;
    end else begin
      seen    = pins_d2;
      pins_d2 = pins_d1;
      pins_d1 = {a_in, b_in};
      if (run > 0 && seen == last_seen) run = (run < 1000) ? run + 1 : run;
      else run = 1;
      last_seen = seen;
      m_step = 1'b0;
      if (run >= int'(FILT_LEN)) begin
        if (!m_primed) begin
          m_primed = 1'b1;
          m_ab     = seen;
        end else if (seen != m_ab) begin
          d = (gpos(seen) - gpos(m_ab) + 4) % 4;
          if (d == 1) begin m_dir = 1'b1; m_step = en; end
          else if (d == 3) begin m_dir = 1'b0; m_step = en; end
          else begin
            m_err = 1'b1;
            if (m_ecnt < ERR_MAX) m_ecnt++;
          end
          m_ab = seen;
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("model_step", int'(step), int'(m_step));
      chk("model_dir", int'(dir), int'(m_dir));
      chk("model_err", int'(err), int'(m_err));
      chk("model_ab_state", int'(ab_state), int'(m_ab));
`ifdef QDEC_ERR_CNT_EN
      chk("model_err_cnt", int'(err_cnt), m_ecnt);
`endif
    end
  end

  // Step tally and a 3-bit up/down counter fed by step/dir
  int       steps = 0;
  logic [2:0] ctr3 = 3'b000;
  always @(posedge clk) begin
    logic r;
    r = rst;
    #2;
    if (r) ctr3 = 3'b000;
    else if (step) begin
      steps++;
      ctr3 = dir ? ctr3 + 3'd1 : ctr3 - 3'd1;
    end
  end

  task automatic do_reset(input logic [1:0] p);
    @(negedge clk);
    rst = 1'b1;
    {a_in, b_in} = p;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [1:0] p, input int n);
    @(negedge clk);
    {a_in, b_in} = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply a legal transition and require step exactly on the 5th edge
  task automatic step_at(input logic [1:0] p, input string name);
    @(negedge clk);
    {a_in, b_in} = p;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk(name, int'(step), (i == 5) ? 1 : 0);
    end
  endtask

  initial begin
    int         base;
    logic [1:0] cur;
    int         mv;

    // Priming at 11: no step, no error
    do_reset(2'b11);
    base = steps;
    drive(2'b11, 10);
    chk("prime_ab", int'(ab_state), 3);
    chk("prime_err", int'(err), 0);
    chk("prime_dir", int'(dir), 1);
    chk("prime_steps", steps - base, 0);

    // Forward sequence with latency check
    do_reset(2'b00);
    drive(2'b00, 8);
    base = steps;
    step_at(2'b01, "fwd_step_01");
    step_at(2'b11, "fwd_step_11");
    step_at(2'b10, "fwd_step_10");
    step_at(2'b00, "fwd_step_00");
    chk("fwd_steps", steps - base, 4);
    chk("fwd_dir", int'(dir), 1);
    chk("fwd_ab", int'(ab_state), 0);

    // Reverse sequence drives the counter from 000 to 100
    do_reset(2'b00);
    drive(2'b00, 8);
    step_at(2'b10, "rev_step_10");
    chk("rev_dir_first", int'(dir), 0);
    step_at(2'b11, "rev_step_11");
    step_at(2'b01, "rev_step_01");
    step_at(2'b00, "rev_step_00");
    chk("rev_ctr3", int'(ctr3), 4);
    chk("rev_dir", int'(dir), 0);

    // Two-cycle glitch on A is discarded, the following 01 steps once
    do_reset(2'b00);
    drive(2'b00, 8);
    base = steps;
    drive(2'b10, 2);
    drive(2'b01, 6);
    chk("glitch_steps", steps - base, 1);
    chk("glitch_ab", int'(ab_state), 1);
    chk("glitch_dir", int'(dir), 1);

    // Illegal jump 01 -> 10, then repeated to saturate the count
    do_reset(2'b01);
    drive(2'b01, 10);
    base = steps;
    drive(2'b10, 8);
    chk("illegal_err", int'(err), 1);
    chk("illegal_ab", int'(ab_state), 2);
    chk("illegal_dir", int'(dir), 1);
    chk("illegal_steps", steps - base, 0);
    for (int i = 0; i < 19; i++) drive((i % 2 == 0) ? 2'b01 : 2'b10, 6);
    chk("illegal_err_sticky", int'(err), 1);
`ifdef QDEC_ERR_CNT_EN
    chk("err_cnt_sat", int'(err_cnt), 15);
`endif

    // en=0 suppresses steps only; then reset mid-sequence
    do_reset(2'b00);
    drive(2'b00, 8);
    base = steps;
    en = 1'b0;
    drive(2'b01, 6);
    chk("en0_ab_01", int'(ab_state), 1);
    drive(2'b11, 6);
    chk("en0_ab_11", int'(ab_state), 3);
    drive(2'b10, 6);
    chk("en0_ab_10", int'(ab_state), 2);
    chk("en0_steps", steps - base, 0);
    chk("en0_dir", int'(dir), 1);
    en = 1'b1;
    drive(2'b00, 8);
    chk("en1_steps", steps - base, 1);
    chk("en1_ab", int'(ab_state), 0);
    drive(2'b01, 2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_err", int'(err), 0);
    chk("rst_ab", int'(ab_state), 0);

    // Randomized walk with glitches, illegal jumps, en toggling and resets
    cur = 2'b00;
    do_reset(cur);
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 99) < 2) do_reset(cur);
      mv = $urandom_range(0, 9);
      if (mv <= 3) cur = gval(gpos(cur) + 1);
      else if (mv <= 6) cur = gval(gpos(cur) + 3);
      else if (mv == 7) cur = gval(gpos(cur) + 2);
      en = ($urandom_range(0, 3) != 0);
      drive(cur, $urandom_range(1, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
